// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the up/down Gray counter.
// The functions work on a wide word; callers zero-extend and truncate to their own width.
package gray_pkg;

    localparam int unsigned GRAY_DEFAULT_WIDTH = 4;
    localparam int unsigned GRAY_MAX_WIDTH     = 32;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    // Zero-extension keeps both conversions exact for any width up to GRAY_MAX_WIDTH
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_encoder.sv
// Combinational WIDTH-bit binary to Gray encoder.
module gray_encoder
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    gray_word_t wide_gray;

    always_comb begin
        wide_gray = bin2gray(GRAY_MAX_WIDTH'(bin));
        gray_c    = wide_gray[WIDTH-1:0];
    end

endmodule

// File: rtl/up_down_gray_counter.sv
// Free-running up/down counter with a registered Gray-coded output.
// Binary state and Gray output register load together from the same next value.
module up_down_gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    output logic [WIDTH-1:0] gray
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_next_c;
    logic [WIDTH-1:0] gray_next_c;

    always_comb begin
        bin_next_c = bin_q;
        if (mode) begin
            bin_next_c = bin_q + WIDTH'(1);
        end else begin
            bin_next_c = bin_q - WIDTH'(1);
        end
    end

    gray_encoder #(
        .WIDTH (WIDTH)
    ) u_gray_encoder (
        .bin    (bin_next_c),
        .gray_c (gray_next_c)
    );

    // Encoding the next value keeps gray purely registered, with no path from mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q <= '0;
            gray  <= '0;
        end else begin
            bin_q <= bin_next_c;
            gray  <= gray_next_c;
        end
    end

endmodule

// File: tb/tb_up_down_gray_counter.sv
// Directed bench for up_down_gray_counter with a queue scoreboard fed from a code table.
module tb_up_down_gray_counter;
    import gray_pkg::*;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset;
    logic         mode;
    logic [W-1:0] gray;

    up_down_gray_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .gray  (gray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] seq [16];
    logic [W-1:0] exp_q [$];
    int           ref_bin;
    logic [W-1:0] prev_gray;
    logic [W-1:0] expv;
    logic [W-1:0] decoded;
    int           checks;
    int           errors;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, req);
        end
    endtask

    // One clock edge with the given direction; expected code queued at drive time
    task automatic step(input logic m, input string tag);
        int diff;
        mode = m;
        ref_bin = m ? (ref_bin + 1) % 16 : (ref_bin + 15) % 16;
        exp_q.push_back(seq[ref_bin]);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            expv = exp_q.pop_front();
            check(tag, gray, expv);
        end
        diff = $countones(gray ^ prev_gray);
        checks++;
        assert (diff == 1) else begin
            errors++;
            $error("FAIL %s_onebit observed=%0d expected=1", tag, diff);
        end
        decoded = W'(gray2bin(GRAY_MAX_WIDTH'(gray)));
        check({tag, "_bin"}, decoded, W'(ref_bin));
        prev_gray = gray;
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1 check(tag, gray, '0);
        ref_bin   = 0;
        prev_gray = '0;
        #1 reset = 1'b0;
    endtask

    initial begin
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        checks    = 0;
        errors    = 0;
        ref_bin   = 0;
        prev_gray = '0;
        mode      = 1'bx;
        reset     = 1'b1;

        // Reset held across edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", gray, '0);
        mode = 1'b1;
        @(negedge clk);
        check("reset_hold_mode1", gray, '0);
        reset = 1'b0;

        // Full up sequence with wrap back to 0000
        for (int i = 0; i < 16; i++) step(1'b1, $sformatf("up_%0d", i));
        check("up_wrap_zero", gray, 4'b0000);

        // Down from 0000 wraps to 1000 then decreases
        for (int i = 0; i < 4; i++) step(1'b0, $sformatf("down_%0d", i));
        check("down_end", gray, 4'b1010);

        // Asynchronous clear between edges
        async_reset_pulse("async_clear_1");

        // Up five then reverse for two
        for (int i = 0; i < 5; i++) step(1'b1, $sformatf("rev_up_%0d", i));
        check("rev_peak", gray, 4'b0111);
        step(1'b0, "rev_down_0");
        step(1'b0, "rev_down_1");
        check("rev_end", gray, 4'b0010);

        // Climb to 1100 then reset mid-count
        for (int i = 0; i < 5; i++) step(1'b1, $sformatf("climb_%0d", i));
        check("climb_end", gray, 4'b1100);
        async_reset_pulse("async_clear_1100");
        step(1'b1, "post_reset_up");
        check("post_reset_up_val", gray, 4'b0001);

        // First edge after reset in the down direction
        async_reset_pulse("async_clear_2");
        step(1'b0, "post_reset_down");
        check("post_reset_down_val", gray, 4'b1000);

        // Alternating direction must never skip or repeat a code
        for (int i = 0; i < 12; i++) step(1'(($urandom_range(0, 1))), $sformatf("rand_%0d", i));

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
